// File: rtl/controlpack.sv
// Shared datapath control package: register file operation encoding.
package controlpack;

    typedef enum logic [2:0] {
        REGF_NOP   = 3'd0,
        REGF_WRITE = 3'd1,
        REGF_INC   = 3'd2,
        REGF_DEC   = 3'd3,
        REGF_MOVE  = 3'd4,
        REGF_SWAP  = 3'd5,
        REGF_CLEAR = 3'd6,
        REGF_BANK  = 3'd7
    } regfile_op_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// CLEAR sweep sequencer: IDLE/CLEARING FSM walking clear_idx across the bank.
// State advances on the falling clock edge to match the rest of the datapath.
module regfile_clear_seq #(
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned SEL_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 clear_en,
    output logic [SEL_WIDTH-1:0] clear_idx
);

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } seq_state_e;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

    seq_state_e           state, state_nxt;
    logic [SEL_WIDTH-1:0] count, count_nxt;
    logic                 busy_nxt;

    // State, counter and busy registers
    always_ff @(negedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next state; entry 0 is cleared on the accepting edge, the rest one per edge
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        busy_nxt  = busy;
        clear_en  = 1'b0;
        clear_idx = count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clear_en  = 1'b1;
                    clear_idx = '0;
                    count_nxt = SEL_WIDTH'(1);
                    busy_nxt  = 1'b1;
                    state_nxt = CLEARING;
                end
            end
            CLEARING: begin
                clear_en = 1'b1;
                if (count == LAST_IDX) begin
                    count_nxt = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + SEL_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/register_file.sv
// Parametrised datapath register file with in-place INC/DEC/MOVE/SWAP,
// a registered wrap flag and a multi-cycle CLEAR sweep.
// Optional second register bank selected by REGF_BANK when REGFILE_SHADOW_EN
// is defined; otherwise REGF_BANK is a NOP.
module register_file
    import controlpack::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned NUM_REGS       = 8,
    localparam int unsigned SEL_WIDTH     = $clog2(NUM_REGS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  regfile_op_e               op,
    input  logic [SEL_WIDTH-1:0]      rd_sel,
    input  logic [SEL_WIDTH-1:0]      rs1_sel,
    input  logic [SEL_WIDTH-1:0]      rs2_sel,
    input  logic [DATA_BUS_WIDTH-1:0] wr_data,
    output logic [DATA_BUS_WIDTH-1:0] rs1_data,
    output logic [DATA_BUS_WIDTH-1:0] rs2_data,
    output logic                      wrap,
    output logic                      busy
);

    logic [DATA_BUS_WIDTH-1:0] bank0 [NUM_REGS];
`ifdef REGFILE_SHADOW_EN
    logic [DATA_BUS_WIDTH-1:0] bank1 [NUM_REGS];
    logic                      bank_sel, bank_sel_nxt;
`endif

    logic [DATA_BUS_WIDTH-1:0] cur [NUM_REGS];
    logic [DATA_BUS_WIDTH-1:0] nxt [NUM_REGS];
    logic                      wrap_nxt;
    logic                      clear_start;
    logic                      clear_en;
    logic [SEL_WIDTH-1:0]      clear_idx;

    assign clear_start = (op == REGF_CLEAR);

    regfile_clear_seq #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .start     (clear_start),
        .busy      (busy),
        .clear_en  (clear_en),
        .clear_idx (clear_idx)
    );

    // Active bank view used by reads and by the op datapath
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
`ifdef REGFILE_SHADOW_EN
            cur[i] = bank_sel ? bank1[i] : bank0[i];
`else
            cur[i] = bank0[i];
`endif
        end
    end

    assign rs1_data = cur[rs1_sel];
    assign rs2_data = cur[rs2_sel];

    // Next contents of the active bank and next wrap flag
    always_comb begin
        nxt      = cur;
        wrap_nxt = wrap;
`ifdef REGFILE_SHADOW_EN
        bank_sel_nxt = bank_sel;
`endif
        if (!busy) begin
            unique case (op)
                REGF_WRITE: begin
                    nxt[rd_sel] = wr_data;
                    wrap_nxt    = 1'b0;
                end
                REGF_INC: begin
                    nxt[rd_sel] = cur[rd_sel] + DATA_BUS_WIDTH'(1);
                    wrap_nxt    = &cur[rd_sel];
                end
                REGF_DEC: begin
                    nxt[rd_sel] = cur[rd_sel] - DATA_BUS_WIDTH'(1);
                    wrap_nxt    = (cur[rd_sel] == '0);
                end
                REGF_MOVE: begin
                    nxt[rd_sel] = cur[rs1_sel];
                    wrap_nxt    = 1'b0;
                end
                REGF_SWAP: begin
                    // rd == rs1 falls out as a no-op: both writes carry the same value
                    nxt[rd_sel]  = cur[rs1_sel];
                    nxt[rs1_sel] = cur[rd_sel];
                    wrap_nxt     = 1'b0;
                end
                REGF_CLEAR: begin
                    wrap_nxt = 1'b0;
                end
`ifdef REGFILE_SHADOW_EN
                REGF_BANK: begin
                    bank_sel_nxt = ~bank_sel;
                    wrap_nxt     = 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
        if (clear_en) begin
            nxt[clear_idx] = '0;
        end
    end

    // Storage, bank select and wrap registers
    always_ff @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                bank0[i] <= '0;
`ifdef REGFILE_SHADOW_EN
                bank1[i] <= '0;
`endif
            end
`ifdef REGFILE_SHADOW_EN
            bank_sel <= 1'b0;
`endif
            wrap <= 1'b0;
        end else begin
`ifdef REGFILE_SHADOW_EN
            if (bank_sel) begin
                bank1 <= nxt;
            end else begin
                bank0 <= nxt;
            end
            bank_sel <= bank_sel_nxt;
`else
            bank0 <= nxt;
`endif
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (8 x 8-bit default build).
// State changes on the falling edge; inputs are driven and outputs sampled
// just after the rising edge.
module tb_register_file;
    import controlpack::*;

    localparam int unsigned W = 8;
    localparam int unsigned N = 8;
    localparam int unsigned S = 3;

    logic          clock;
    logic          reset;
    regfile_op_e   op;
    logic [S-1:0]  rd_sel;
    logic [S-1:0]  rs1_sel;
    logic [S-1:0]  rs2_sel;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  rs1_data;
    logic [W-1:0]  rs2_data;
    logic          wrap;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    register_file #(
        .DATA_BUS_WIDTH (W),
        .NUM_REGS       (N)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .op       (op),
        .rd_sel   (rd_sel),
        .rs1_sel  (rs1_sel),
        .rs2_sel  (rs2_sel),
        .wr_data  (wr_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wrap     (wrap),
        .busy     (busy)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one active (falling) edge and park just after the rising edge
    task automatic tick();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input regfile_op_e o, input int rd, input int rs1, input logic [W-1:0] wd);
        op      = o;
        rd_sel  = S'(rd);
        rs1_sel = S'(rs1);
        wr_data = wd;
        tick();
        op = REGF_NOP;
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [W-1:0] exp);
        rs1_sel = S'(idx);
        rs2_sel = S'(N - 1 - idx);
        #1;
        check(tag, 32'(rs1_data), 32'(exp));
    endtask

    task automatic chk_reg2(input string tag, input int idx, input logic [W-1:0] exp);
        rs2_sel = S'(idx);
        #1;
        check(tag, 32'(rs2_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        op      = REGF_NOP;
        rd_sel  = '0;
        rs1_sel = '0;
        rs2_sel = '0;
        wr_data = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        for (int i = 0; i < int'(N); i++) chk_reg2("reset_reg", i, 8'h00);

        // WRITE: invisible before the edge, visible after; no other register touched
        op = REGF_WRITE; rd_sel = 3'd3; wr_data = 8'h5A; rs1_sel = 3'd3;
        #1;
        check("write_before_edge", 32'(rs1_data), 32'h00);
        tick();
        op = REGF_NOP;
        chk_reg("write_after_edge", 3, 8'h5A);
        chk_reg2("write_rs2_port", 3, 8'h5A);
        for (int i = 0; i < int'(N); i++) if (i != 3) chk_reg("write_others_zero", i, 8'h00);

        // INC/DEC wrap flag
        do_op(REGF_WRITE, 5, 0, 8'hFF);
        do_op(REGF_INC, 5, 0, 8'h00);
        chk_reg("inc_ff_value", 5, 8'h00);
        check("inc_ff_wrap", 32'(wrap), 32'd1);
        do_op(REGF_DEC, 5, 0, 8'h00);
        chk_reg("dec_zero_value", 5, 8'hFF);
        check("dec_zero_wrap", 32'(wrap), 32'd1);
        do_op(REGF_NOP, 0, 0, 8'h00);
        check("nop_holds_wrap", 32'(wrap), 32'd1);
        do_op(REGF_WRITE, 6, 0, 8'h01);
        check("write_clears_wrap", 32'(wrap), 32'd0);
        do_op(REGF_INC, 6, 0, 8'h00);
        chk_reg("inc_plain", 6, 8'h02);
        check("inc_plain_wrap", 32'(wrap), 32'd0);
        do_op(REGF_INC, 5, 0, 8'h00);
        check("inc_ff_wrap_again", 32'(wrap), 32'd1);
        do_op(REGF_DEC, 6, 0, 8'h00);
        chk_reg("dec_plain", 6, 8'h01);
        check("dec_plain_clears_wrap", 32'(wrap), 32'd0);

        // SWAP / MOVE
        do_op(REGF_WRITE, 1, 0, 8'h11);
        do_op(REGF_WRITE, 2, 0, 8'h22);
        do_op(REGF_SWAP, 1, 2, 8'h00);
        chk_reg("swap_reg1", 1, 8'h22);
        chk_reg("swap_reg2", 2, 8'h11);
        do_op(REGF_WRITE, 4, 0, 8'h44);
        do_op(REGF_SWAP, 4, 4, 8'h00);
        chk_reg("swap_self", 4, 8'h44);
        do_op(REGF_MOVE, 0, 2, 8'h00);
        chk_reg("move_reg0", 0, 8'h11);
        chk_reg("move_src_kept", 2, 8'h11);

        `ifndef REGFILE_SHADOW_EN
        // BANK compiled out behaves as NOP: contents and wrap hold
        do_op(REGF_WRITE, 7, 0, 8'hFF);
        do_op(REGF_INC, 7, 0, 8'h00);
        do_op(REGF_BANK, 0, 0, 8'h00);
        check("bank_nop_wrap", 32'(wrap), 32'd1);
        chk_reg("bank_nop_reg1", 1, 8'h22);
        `endif

        // CLEAR sweep with a WRITE held on op throughout
        for (int i = 0; i < int'(N); i++) do_op(REGF_WRITE, i, 0, 8'(8'h80 + i));
        op = REGF_CLEAR;
        tick();
        op = REGF_WRITE; rd_sel = 3'd7; wr_data = 8'hAB;
        for (int c = 1; c < int'(N); c++) begin
            check("sweep_busy", 32'(busy), 32'd1);
            chk_reg("sweep_prev_cleared", c - 1, 8'h00);
            chk_reg2("sweep_next_intact", c, 8'(8'h80 + c));
            tick();
            if (c == int'(N) - 1) op = REGF_NOP;
        end
        check("sweep_busy_fall", 32'(busy), 32'd0);
        for (int i = 0; i < int'(N); i++) chk_reg("sweep_all_zero", i, 8'h00);

        // Reset on the 3rd sweep cycle aborts the sweep
        for (int i = 0; i < int'(N); i++) do_op(REGF_WRITE, i, 0, 8'(8'hC0 + i));
        do_op(REGF_CLEAR, 0, 0, 8'h00);
        tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < int'(N); i++) chk_reg("abort_zero", i, 8'h00);
        do_op(REGF_WRITE, 7, 0, 8'h33);
        chk_reg("post_abort_write", 7, 8'h33);
        check("post_abort_busy", 32'(busy), 32'd0);

        `ifdef REGFILE_SHADOW_EN
        // Shadow bank toggling keeps each bank's contents
        do_op(REGF_WRITE, 2, 0, 8'hAA);
        do_op(REGF_BANK, 0, 0, 8'h00);
        chk_reg("shadow_bank1_empty", 2, 8'h00);
        do_op(REGF_WRITE, 2, 0, 8'h55);
        do_op(REGF_BANK, 0, 0, 8'h00);
        chk_reg("shadow_bank0_kept", 2, 8'hAA);
        do_op(REGF_BANK, 0, 0, 8'h00);
        chk_reg("shadow_bank1_kept", 2, 8'h55);
        `endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
